// File: rtl/ysyx_24110015_axi_arbiter_if.sv
// AXI4-lite style bundle with rlast shared by the fetch/load-store masters and the memory bus.
interface axi_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rlast;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, rlast, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, rlast, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_24110015_axi_arbiter.sv
// Two-master (ifu/lsu) to one-slave AXI arbiter, one transaction in flight at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise master FIXED_HI wins ties.
module ysyx_24110015_axi_arbiter #(
  parameter int unsigned FIXED_HI = 1
) (
  input  logic       clk,
  input  logic       rst,
  axi_if.slave       ifu,
  axi_if.slave       lsu,
  axi_if.master      mem,
  output logic [1:0] gnt
);

  typedef enum logic [2:0] {StIdle, StIfuRd, StIfuWr, StLsuRd, StLsuWr} state_e;

  state_e state_q, state_d;
  logic   ifu_req, lsu_req, tie_lsu, pick_lsu;
  logic   sel_lsu, rd, wr, rd_done, wr_done;

  assign ifu_req  = ifu.arvalid | ifu.awvalid | ifu.wvalid;
  assign lsu_req  = lsu.arvalid | lsu.awvalid | lsu.wvalid;
  assign pick_lsu = lsu_req & (~ifu_req | tie_lsu);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_lsu_q, last_lsu_d;

  assign tie_lsu = ~last_lsu_q;

  always_comb begin
    last_lsu_d = last_lsu_q;
    if (state_q == StIdle && (ifu_req || lsu_req)) last_lsu_d = pick_lsu;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_lsu_q <= 1'b0;
    else     last_lsu_q <= last_lsu_d;
  end
`else
  assign tie_lsu = (FIXED_HI == 1);
`endif

  assign sel_lsu = (state_q == StLsuRd) || (state_q == StLsuWr);
  assign rd      = (state_q == StIfuRd) || (state_q == StLsuRd);
  assign wr      = (state_q == StIfuWr) || (state_q == StLsuWr);

  // Owner's request-side signals, routed to mem only in the matching state.
  logic [31:0] o_araddr, o_awaddr, o_wdata;
  logic [3:0]  o_wstrb;
  logic        o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready;

  assign o_araddr  = sel_lsu ? lsu.araddr  : ifu.araddr;
  assign o_arvalid = sel_lsu ? lsu.arvalid : ifu.arvalid;
  assign o_rready  = sel_lsu ? lsu.rready  : ifu.rready;
  assign o_awaddr  = sel_lsu ? lsu.awaddr  : ifu.awaddr;
  assign o_awvalid = sel_lsu ? lsu.awvalid : ifu.awvalid;
  assign o_wdata   = sel_lsu ? lsu.wdata   : ifu.wdata;
  assign o_wstrb   = sel_lsu ? lsu.wstrb   : ifu.wstrb;
  assign o_wvalid  = sel_lsu ? lsu.wvalid  : ifu.wvalid;
  assign o_bready  = sel_lsu ? lsu.bready  : ifu.bready;

  assign rd_done = mem.rvalid & o_rready & mem.rlast;
  assign wr_done = mem.bvalid & o_bready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        // A read wins over a simultaneous write from the same master.
        if (pick_lsu)     state_d = lsu.arvalid ? StLsuRd : StLsuWr;
        else if (ifu_req) state_d = ifu.arvalid ? StIfuRd : StIfuWr;
      end
      StIfuRd, StLsuRd: if (rd_done) state_d = StIdle;
      StIfuWr, StLsuWr: if (wr_done) state_d = StIdle;
      default:          state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    mem.araddr  = '0;
    mem.arvalid = 1'b0;
    mem.rready  = 1'b0;
    mem.awaddr  = '0;
    mem.awvalid = 1'b0;
    mem.wdata   = '0;
    mem.wstrb   = '0;
    mem.wvalid  = 1'b0;
    mem.bready  = 1'b0;
    if (rd) begin
      mem.araddr  = o_araddr;
      mem.arvalid = o_arvalid;
      mem.rready  = o_rready;
    end
    if (wr) begin
      mem.awaddr  = o_awaddr;
      mem.awvalid = o_awvalid;
      mem.wdata   = o_wdata;
      mem.wstrb   = o_wstrb;
      mem.wvalid  = o_wvalid;
      mem.bready  = o_bready;
    end
  end

  always_comb begin
    ifu.arready = 1'b0;
    ifu.rdata   = '0;
    ifu.rresp   = '0;
    ifu.rvalid  = 1'b0;
    ifu.rlast   = 1'b0;
    ifu.awready = 1'b0;
    ifu.wready  = 1'b0;
    ifu.bresp   = '0;
    ifu.bvalid  = 1'b0;
    lsu.arready = 1'b0;
    lsu.rdata   = '0;
    lsu.rresp   = '0;
    lsu.rvalid  = 1'b0;
    lsu.rlast   = 1'b0;
    lsu.awready = 1'b0;
    lsu.wready  = 1'b0;
    lsu.bresp   = '0;
    lsu.bvalid  = 1'b0;
    if (rd && !sel_lsu) begin
      ifu.arready = mem.arready;
      ifu.rdata   = mem.rdata;
      ifu.rresp   = mem.rresp;
      ifu.rvalid  = mem.rvalid;
      ifu.rlast   = mem.rlast;
    end
    if (wr && !sel_lsu) begin
      ifu.awready = mem.awready;
      ifu.wready  = mem.wready;
      ifu.bresp   = mem.bresp;
      ifu.bvalid  = mem.bvalid;
    end
    if (rd && sel_lsu) begin
      lsu.arready = mem.arready;
      lsu.rdata   = mem.rdata;
      lsu.rresp   = mem.rresp;
      lsu.rvalid  = mem.rvalid;
      lsu.rlast   = mem.rlast;
    end
    if (wr && sel_lsu) begin
      lsu.awready = mem.awready;
      lsu.wready  = mem.wready;
      lsu.bresp   = mem.bresp;
      lsu.bvalid  = mem.bvalid;
    end
  end

  always_comb begin
    case (state_q)
      StIfuRd, StIfuWr: gnt = 2'b01;
      StLsuRd, StLsuWr: gnt = 2'b10;
      default:          gnt = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_ysyx_24110015_axi_arbiter.sv
// Bench for ysyx_24110015_axi_arbiter: vector table, directed corner sequences, random vs model.
module tb_ysyx_24110015_axi_arbiter;

  localparam int unsigned FixedHi = 1;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] araddr; logic arvalid; logic rready;
    logic [31:0] awaddr; logic awvalid; logic [31:0] wdata; logic [3:0] wstrb;
    logic wvalid; logic bready;
  } mreq_t;

  typedef struct packed {
    logic arready; logic [31:0] rdata; logic [1:0] rresp; logic rvalid; logic rlast;
    logic awready; logic wready; logic [1:0] bresp; logic bvalid;
  } srsp_t;

  typedef struct packed {
    mreq_t mem; srsp_t ifu; srsp_t lsu; logic [1:0] gnt;
  } outs_t;

  typedef struct packed {
    logic [2:0] ireq; logic [2:0] lreq; logic [1:0] gnt; logic [1:0] kind;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] gnt;
  mreq_t ifu_in, lsu_in;
  srsp_t mem_in;
  outs_t act;
  int checks = 0;
  int failures = 0;

  // Model state: owner 0 none / 1 ifu / 2 lsu, last winner for round-robin.
  int owner;
  bit is_rd;
  int last_win;

  always #5 clk = ~clk;

  axi_if ifu_b ();
  axi_if lsu_b ();
  axi_if mem_b ();

  ysyx_24110015_axi_arbiter #(.FIXED_HI(FixedHi)) dut (
    .clk (clk),
    .rst (rst),
    .ifu (ifu_b),
    .lsu (lsu_b),
    .mem (mem_b),
    .gnt (gnt)
  );

  assign ifu_b.araddr = ifu_in.araddr;   assign ifu_b.arvalid = ifu_in.arvalid;
  assign ifu_b.rready = ifu_in.rready;   assign ifu_b.awaddr = ifu_in.awaddr;
  assign ifu_b.awvalid = ifu_in.awvalid; assign ifu_b.wdata = ifu_in.wdata;
  assign ifu_b.wstrb = ifu_in.wstrb;     assign ifu_b.wvalid = ifu_in.wvalid;
  assign ifu_b.bready = ifu_in.bready;
  assign lsu_b.araddr = lsu_in.araddr;   assign lsu_b.arvalid = lsu_in.arvalid;
  assign lsu_b.rready = lsu_in.rready;   assign lsu_b.awaddr = lsu_in.awaddr;
  assign lsu_b.awvalid = lsu_in.awvalid; assign lsu_b.wdata = lsu_in.wdata;
  assign lsu_b.wstrb = lsu_in.wstrb;     assign lsu_b.wvalid = lsu_in.wvalid;
  assign lsu_b.bready = lsu_in.bready;
  assign mem_b.arready = mem_in.arready; assign mem_b.rdata = mem_in.rdata;
  assign mem_b.rresp = mem_in.rresp;     assign mem_b.rvalid = mem_in.rvalid;
  assign mem_b.rlast = mem_in.rlast;     assign mem_b.awready = mem_in.awready;
  assign mem_b.wready = mem_in.wready;   assign mem_b.bresp = mem_in.bresp;
  assign mem_b.bvalid = mem_in.bvalid;

  assign act = {
    mem_b.araddr, mem_b.arvalid, mem_b.rready, mem_b.awaddr, mem_b.awvalid,
    mem_b.wdata, mem_b.wstrb, mem_b.wvalid, mem_b.bready,
    ifu_b.arready, ifu_b.rdata, ifu_b.rresp, ifu_b.rvalid, ifu_b.rlast,
    ifu_b.awready, ifu_b.wready, ifu_b.bresp, ifu_b.bvalid,
    lsu_b.arready, lsu_b.rdata, lsu_b.rresp, lsu_b.rvalid, lsu_b.rlast,
    lsu_b.awready, lsu_b.wready, lsu_b.bresp, lsu_b.bvalid,
    gnt
  };

  task automatic chk(input string name, input logic [190:0] got, input logic [190:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ifu_in = '0;
    lsu_in = '0;
    mem_in = '0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Expected outputs: the owner's channels of the active direction pass straight through.
  function automatic outs_t model_out();
    outs_t e;
    mreq_t m;
    srsp_t r;
    e = '0;
    r = '0;
    if (owner == 0) return e;
    e.gnt = (owner == 1) ? 2'b01 : 2'b10;
    m = (owner == 1) ? ifu_in : lsu_in;
    if (is_rd) begin
      e.mem.araddr = m.araddr; e.mem.arvalid = m.arvalid; e.mem.rready = m.rready;
      r.arready = mem_in.arready; r.rdata = mem_in.rdata; r.rresp = mem_in.rresp;
      r.rvalid = mem_in.rvalid; r.rlast = mem_in.rlast;
    end else begin
      e.mem.awaddr = m.awaddr; e.mem.awvalid = m.awvalid; e.mem.wdata = m.wdata;
      e.mem.wstrb = m.wstrb; e.mem.wvalid = m.wvalid; e.mem.bready = m.bready;
      r.awready = mem_in.awready; r.wready = mem_in.wready;
      r.bresp = mem_in.bresp; r.bvalid = mem_in.bvalid;
    end
    if (owner == 1) e.ifu = r;
    else e.lsu = r;
    return e;
  endfunction

  task automatic model_edge();
    bit ri, rl;
    int w;
    mreq_t m;
    ri = ifu_in.arvalid | ifu_in.awvalid | ifu_in.wvalid;
    rl = lsu_in.arvalid | lsu_in.awvalid | lsu_in.wvalid;
    m = (owner == 1) ? ifu_in : lsu_in;
    if (owner == 0) begin
      if (ri && rl) w = RrEn ? ((last_win == 1) ? 2 : 1) : ((FixedHi == 1) ? 2 : 1);
      else if (ri) w = 1;
      else if (rl) w = 2;
      else w = 0;
      if (w != 0) begin
        owner = w;
        is_rd = (w == 1) ? ifu_in.arvalid : lsu_in.arvalid;
        last_win = w;
      end
    end else if (is_rd) begin
      if (mem_in.rvalid && m.rready && mem_in.rlast) owner = 0;
    end else if (mem_in.bvalid && m.bready) begin
      owner = 0;
    end
  endtask

  function automatic mreq_t rand_m();
    mreq_t m;
    m.araddr = $urandom; m.arvalid = ($urandom_range(0, 3) == 0);
    m.rready = ($urandom_range(0, 9) < 7); m.awaddr = $urandom;
    m.awvalid = ($urandom_range(0, 4) == 0); m.wdata = $urandom;
    m.wstrb = 4'($urandom); m.wvalid = ($urandom_range(0, 4) == 0);
    m.bready = ($urandom_range(0, 9) < 7);
    return m;
  endfunction

  function automatic srsp_t rand_s();
    srsp_t s;
    s.arready = 1'($urandom); s.rdata = $urandom; s.rresp = 2'($urandom);
    s.rvalid = ($urandom_range(0, 9) < 3); s.rlast = 1'($urandom);
    s.awready = 1'($urandom); s.wready = 1'($urandom); s.bresp = 2'($urandom);
    s.bvalid = ($urandom_range(0, 9) < 3);
    return s;
  endfunction

  initial begin
    vec_t vecs[10];
    int aw_cnt, w_cnt, b_cnt;
    logic [31:0] aw_addr, w_data;
    logic [3:0] w_strb;
    logic ifu_bad;
    logic [1:0] exp_g;

    // Reset-time: requests present, every output must stay 0 during reset and one cycle after.
    clear_in();
    rst = 1'b1;
    ifu_in.arvalid = 1'b1;
    lsu_in.awvalid = 1'b1;
    mem_in.rvalid = 1'b1;
    #3;
    chk("rst_quiet", act, '0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_quiet", act, '0);
    step();
    #1;
    chk("post_rst_grant", gnt, 2'b10);

    // {ifu ar/aw/w, lsu ar/aw/w, expected gnt, expected {mem arvalid, mem awvalid|wvalid}}
    vecs[0] = '{3'b100, 3'b000, 2'b01, 2'b10};
    vecs[1] = '{3'b010, 3'b000, 2'b01, 2'b01};
    vecs[2] = '{3'b001, 3'b000, 2'b01, 2'b01};
    vecs[3] = '{3'b000, 3'b100, 2'b10, 2'b10};
    vecs[4] = '{3'b000, 3'b011, 2'b10, 2'b01};
    vecs[5] = '{3'b110, 3'b000, 2'b01, 2'b10};
    vecs[6] = '{3'b000, 3'b110, 2'b10, 2'b10};
    vecs[7] = '{3'b100, 3'b100, 2'b10, 2'b10};
    vecs[8] = '{3'b010, 3'b001, 2'b10, 2'b01};
    vecs[9] = '{3'b000, 3'b000, 2'b00, 2'b00};
    for (int i = 0; i < 10; i++) begin
      do_reset();
      {ifu_in.arvalid, ifu_in.awvalid, ifu_in.wvalid} = vecs[i].ireq;
      {lsu_in.arvalid, lsu_in.awvalid, lsu_in.wvalid} = vecs[i].lreq;
      #1;
      chk($sformatf("vec%0d_idle", i),
          {gnt, mem_b.arvalid, mem_b.awvalid, mem_b.wvalid}, '0);
      step();
      #1;
      chk($sformatf("vec%0d_gnt", i), gnt, vecs[i].gnt);
      chk($sformatf("vec%0d_kind", i),
          {mem_b.arvalid, mem_b.awvalid | mem_b.wvalid}, vecs[i].kind);
    end

    // ifu fetch at 0x80000000, data returns three cycles after the address.
    do_reset();
    ifu_in.arvalid = 1'b1;
    ifu_in.araddr = 32'h8000_0000;
    ifu_in.rready = 1'b1;
    mem_in.arready = 1'b1;
    #1;
    chk("a_gnt0", gnt, 2'b00);
    step();
    #1;
    chk("a_gnt1", gnt, 2'b01);
    chk("a_araddr", {mem_b.arvalid, mem_b.araddr}, {1'b1, 32'h8000_0000});
    step();
    ifu_in.arvalid = 1'b0;
    mem_in.arready = 1'b0;
    step();
    #1;
    chk("a_wait", {gnt, ifu_b.rvalid}, {2'b01, 1'b0});
    step();
    mem_in.rvalid = 1'b1;
    mem_in.rlast = 1'b1;
    mem_in.rdata = 32'h0000_0413;
    #1;
    chk("a_rdata", {ifu_b.rvalid, ifu_b.rdata}, {1'b1, 32'h0000_0413});
    step();
    mem_in = '0;
    #1;
    chk("a_idle", gnt, 2'b00);

    // Four rounds of simultaneous reads.
    do_reset();
    ifu_in.arvalid = 1'b1;
    ifu_in.rready = 1'b1;
    lsu_in.arvalid = 1'b1;
    lsu_in.rready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int t = 0; t < 5; t++) begin
        step();
        #1;
        if (gnt != 2'b00) break;
      end
      exp_g = (RrEn && (r % 2 == 1)) ? 2'b01 : 2'b10;
      chk($sformatf("b_round%0d", r), gnt, exp_g);
      mem_in.rvalid = 1'b1;
      mem_in.rlast = 1'b1;
      step();
      mem_in.rvalid = 1'b0;
      #1;
      chk($sformatf("b_gap%0d", r), gnt, 2'b00);
    end

    // lsu W two cycles ahead of AW.
    do_reset();
    mem_in.awready = 1'b1;
    mem_in.wready = 1'b1;
    lsu_in.wvalid = 1'b1;
    lsu_in.wdata = 32'hDEAD_BEEF;
    lsu_in.wstrb = 4'b0011;
    lsu_in.bready = 1'b1;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ifu_bad = 1'b0;
    aw_addr = '0; w_data = '0; w_strb = '0;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) begin
        lsu_in.awvalid = 1'b1;
        lsu_in.awaddr = 32'h8000_1000;
      end
      #1;
      ifu_bad |= ifu_b.arready | ifu_b.awready | ifu_b.wready | ifu_b.rvalid | ifu_b.bvalid;
      if (mem_b.wvalid && mem_b.wready) begin
        w_cnt++; w_data = mem_b.wdata; w_strb = mem_b.wstrb;
      end
      if (mem_b.awvalid && mem_b.awready) begin
        aw_cnt++; aw_addr = mem_b.awaddr;
      end
      if (lsu_b.bvalid && lsu_in.bready) b_cnt++;
      step();
      if (w_cnt > 0) lsu_in.wvalid = 1'b0;
      if (aw_cnt > 0) lsu_in.awvalid = 1'b0;
      mem_in.bvalid = (aw_cnt > 0) && (w_cnt > 0) && (b_cnt == 0);
    end
    chk("c_counts", {aw_cnt[3:0], w_cnt[3:0], b_cnt[3:0]}, {4'd1, 4'd1, 4'd1});
    chk("c_aw", aw_addr, 32'h8000_1000);
    chk("c_w", {w_data, w_strb}, {32'hDEAD_BEEF, 4'b0011});
    chk("c_ifu_quiet", ifu_bad, 1'b0);
    chk("c_idle", gnt, 2'b00);

    // lsu read and write together: read first, then write after an idle cycle.
    do_reset();
    {lsu_in.arvalid, lsu_in.awvalid, lsu_in.wvalid} = 3'b111;
    lsu_in.rready = 1'b1;
    lsu_in.bready = 1'b1;
    mem_in.arready = 1'b1;
    step();
    #1;
    chk("d_rd_first", {gnt, mem_b.arvalid, mem_b.awvalid}, {2'b10, 1'b1, 1'b0});
    lsu_in.arvalid = 1'b0;
    mem_in.rvalid = 1'b1;
    mem_in.rlast = 1'b1;
    step();
    mem_in.rvalid = 1'b0;
    #1;
    chk("d_gap", gnt, 2'b00);
    step();
    #1;
    chk("d_wr_second", {gnt, mem_b.arvalid, mem_b.awvalid}, {2'b10, 1'b0, 1'b1});

    // Reset mid write, then a clean ifu read.
    do_reset();
    lsu_in.awvalid = 1'b1;
    lsu_in.wvalid = 1'b1;
    lsu_in.bready = 1'b1;
    mem_in.awready = 1'b1;
    mem_in.wready = 1'b1;
    step();
    #1;
    chk("e_granted", gnt, 2'b10);
    #2;
    rst = 1'b1;
    #1;
    chk("e_rst_quiet", act, '0);
    clear_in();
    step();
    rst = 1'b0;
    ifu_in.arvalid = 1'b1;
    ifu_in.rready = 1'b1;
    mem_in.arready = 1'b1;
    #1;
    chk("e_release_idle", gnt, 2'b00);
    step();
    ifu_in.arvalid = 1'b0;
    mem_in.rvalid = 1'b1;
    mem_in.rlast = 1'b1;
    mem_in.rdata = 32'hCAFE_0001;
    #1;
    chk("e_ifu_read", {gnt, ifu_b.rvalid, ifu_b.rdata}, {2'b01, 1'b1, 32'hCAFE_0001});
    step();
    mem_in = '0;
    #1;
    chk("e_done", gnt, 2'b00);

    // ifu holds rready low: ownership stays with ifu while lsu waits.
    do_reset();
    ifu_in.arvalid = 1'b1;
    mem_in.arready = 1'b1;
    step();
    #1;
    chk("f_gnt", gnt, 2'b01);
    ifu_in.arvalid = 1'b0;
    lsu_in.arvalid = 1'b1;
    lsu_in.rready = 1'b1;
    mem_in.rvalid = 1'b1;
    mem_in.rlast = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      #1;
      chk($sformatf("f_hold%0d", k), {gnt, lsu_b.arready, lsu_b.rvalid}, {2'b01, 2'b00});
    end
    ifu_in.rready = 1'b1;
    step();
    ifu_in.rready = 1'b0;
    mem_in.rvalid = 1'b0;
    #1;
    chk("f_idle", gnt, 2'b00);
    step();
    #1;
    chk("f_lsu", gnt, 2'b10);

    // Random traffic against the reference model.
    do_reset();
    owner = 0;
    is_rd = 1'b0;
    last_win = 1;
    for (int n = 0; n < 400; n++) begin
      ifu_in = rand_m();
      lsu_in = rand_m();
      mem_in = rand_s();
      #1;
      chk("rand", act, model_out());
      model_edge();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_24110015_axi_arbiter.md
YSYX_24110015_AXI_ARBITER -- requirements
Module: ysyx_24110015_axi_arbiter

Interface
REQ-001 SHALL provide parameter FIXED_HI, default 1: index of the master that wins simultaneous requests when round-robin is compiled out (1 = LSU, 0 = IFU).
REQ-002 SHALL provide port clk  input  1  clock, all state updates on the rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port ifu  axi_if.slave  bundle  master 0 (instruction fetch): AR/R/AW/W/B channels, 32-bit addr/data, 4-bit wstrb, 2-bit resp, rlast.
REQ-005 SHALL provide port lsu  axi_if.slave  bundle  master 1 (load/store unit), same signal set as ifu.
REQ-006 SHALL provide port mem  axi_if.master  bundle  the single shared downstream slave (memory/SoC bus).
REQ-007 SHALL provide port gnt  output  2  debug: current owner, 2'b00 none, 2'b01 ifu, 2'b10 lsu.

Function
REQ-008 SHALL implement states IDLE, IFU_RD, IFU_WR, LSU_RD, LSU_WR; only one transaction is outstanding on mem at any time.
REQ-009 SHALL treat a master as requesting in IDLE when it drives arvalid, awvalid or wvalid.
REQ-010 SHALL hold every ready/valid toward all masters and toward mem at 0 while in IDLE; grant takes effect the cycle after the request is seen (1-cycle arbitration latency).
REQ-011 SHALL select the read transaction when the winning master asserts arvalid together with awvalid/wvalid; the write is served by a later grant.
REQ-012 SHALL, in *_RD states, connect the owner's AR and R channels combinationally to mem (araddr, arvalid, arready, rdata, rresp, rvalid, rlast, rready); mem AW/W/B valids and readys SHALL be 0.
REQ-013 SHALL, in *_WR states, connect the owner's AW, W and B channels combinationally to mem; mem arvalid and rready SHALL be 0.
REQ-014 SHALL drive the non-owner's arready, awready, wready, rvalid, bvalid to 0 and its rdata/bresp to 0; the non-owner's pending valids stay pending and are not dropped.
REQ-015 SHALL leave *_RD for IDLE on the cycle mem rvalid & rready & rlast is 1.
REQ-016 SHALL leave *_WR for IDLE on the cycle mem bvalid & bready is 1; AW and W may complete in either order or together before B.
REQ-017 SHALL spend at least one IDLE cycle between consecutive grants, including back-to-back requests from the same master.
REQ-018 SHALL update gnt from the registered state: 2'b00 in IDLE, 2'b01 in IFU_*, 2'b10 in LSU_*.
REQ-019 SHALL keep the owner locked when mem stalls: no timeout, no preemption.
REQ-020 SHALL go to IDLE on an illegal state encoding.

Reset
REQ-021 SHALL force state to IDLE asynchronously on rst=1, including mid-transaction; gnt=2'b00.
REQ-022 SHALL hold all outputs to both masters and to mem at 0 while rst=1 and in the first cycle after release.
REQ-023 SHALL reset the round-robin last-winner register to ifu (lsu wins the first tie).

Configuration
REQ-024 SHALL compile round-robin arbitration when ARB_ROUND_ROBIN_EN is defined.
REQ-025 SHALL, with ARB_ROUND_ROBIN_EN defined, give a tie to the master that did not win the previous grant, and update last-winner at each grant.
REQ-026 SHALL, without ARB_ROUND_ROBIN_EN, give every tie to master FIXED_HI and contain no last-winner register.
REQ-027 SHALL grant a sole requester in IDLE, regardless of configuration.

Verification
REQ-028 SHALL cover: ifu arvalid, araddr=0x80000000, mem returns 0x00000413 after 3 cycles -> gnt=01 at cycle 1, ifu rdata=0x00000413, IDLE after rlast handshake.
REQ-029 SHALL cover: ifu and lsu arvalid in the same cycle, four rounds -> round-robin grant order lsu, ifu, lsu, ifu; with the macro off and FIXED_HI=1 -> lsu for all rounds while it requests.
REQ-030 SHALL cover: lsu wvalid (wdata=0xDEADBEEF, wstrb=4'b0011) two cycles before awvalid (awaddr=0x80001000) -> one mem write with those values, lsu bvalid once, ifu readys 0 throughout.
REQ-031 SHALL cover: lsu arvalid and awvalid together -> read granted first (LSU_RD), then LSU_WR after an IDLE cycle.
REQ-032 SHALL cover: rst asserted in LSU_WR before bvalid -> state IDLE, gnt=00 and all valids/readys 0 in the same cycle; a fresh ifu read completes after release.
REQ-033 SHALL cover: mem rready held 0 for 5 cycles with lsu pending -> ifu ownership kept until the R handshake; lsu granted after one IDLE cycle.
